serial_arith_ctrl: RTL and testbench
====================================

SERIAL_ARITH_CTRL -- requirements
Module: serial_arith_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits; legal range 2..32.
REQ-002 SHALL have port clk_i, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port start_i, input, 1: request to start an operation; accepted only when ready_o=1.
REQ-005 SHALL have port op_i, input, 2: b-operand select, sampled at accept. Encodings: 00 = B, 01 = ~B, 10 = 0, 11 = all-ones.
REQ-006 SHALL have ports a_i and b_i, each input, WIDTH: operands, sampled at accept.
REQ-007 SHALL have port cin_i, input, 1: initial carry, sampled at accept.
REQ-008 SHALL have port ready_o, output, 1: high only in IDLE.
REQ-009 SHALL have port busy_o, output, 1: high in RUN and DONE.
REQ-010 SHALL have port done_o, output, 1: one-cycle pulse in DONE.
REQ-011 SHALL have port result_o, output, WIDTH: sum of a_i + opB + cin_i.
REQ-012 SHALL have port cout_o, output, 1: carry out of the MSB.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-014 SHALL, in IDLE with start_i=1, latch a_i, b_i, op_i and cin_i into the carry register, clear the bit counter and go to RUN.
REQ-015 SHALL, in RUN, process one bit per cycle, LSB first, through the 1-bit slice:
- slice inputs: a = A[cnt], b = B[cnt], cin = carry register, sel = latched op;
- slice d output shifts into the result shift register from the MSB side;
- slice cout output loads the carry register.
REQ-016 SHALL go from RUN to DONE after bit WIDTH-1 is processed, i.e. after exactly WIDTH RUN cycles.
REQ-017 SHALL go from DONE to IDLE unconditionally after one cycle.
REQ-018 SHALL have latency: start accepted at edge 0, done_o high in cycle WIDTH+1, next start acceptable at cycle WIDTH+2.
REQ-019 SHALL have result_o and cout_o update only at RUN completion and hold from DONE until the next completion; no partial values are visible.
REQ-020 SHALL ignore start_i while busy_o=1, with no effect on latched operands.
REQ-021 SHALL, with start_i held high continuously, accept one operation per WIDTH+2 cycles.
REQ-022 SHALL have the bit counter sized $clog2(WIDTH) and never wrap inside RUN.

Reset
REQ-023 SHALL, on rst_i=1 at any clock edge including mid-RUN:
- go to IDLE;
- clear counter, carry, operands, result_o and cout_o to 0;
- not assert done_o.
REQ-024 SHALL, in the cycle after reset releases, present ready_o=1, busy_o=0 and done_o=0.

Configuration
REQ-025 SHALL, with macro SERIAL_ARITH_OVF_EN defined, add output ovf_o (1 bit): signed overflow = carry into MSB XOR carry out of MSB, registered at completion, reset 0, held like result_o.
REQ-026 SHALL, without SERIAL_ARITH_OVF_EN, have no ovf_o port and no associated logic.

Structure
REQ-027 SHALL take op encodings (OP_ADD_B=00, OP_ADD_NB=01, OP_ADD_ZERO=10, OP_ADD_ONES=11) and the FSM state enum from the shared package serial_arith_pkg.
REQ-028 SHALL instantiate the existing 1-bit arithmetic slice arithmetic_circuit exactly once as its only sub-module; the FSM, counter and shift registers stay in serial_arith_ctrl.

Verification (WIDTH=8)
REQ-029 SHALL check: op=00, a=0x3C, b=0x45, cin=0 -> result_o=0x81, cout_o=0, ovf_o=1, done_o at cycle 9.
REQ-030 SHALL check: op=01, a=0x10, b=0x01, cin=1 -> result_o=0x0F, cout_o=1; op=11, a=0x00, cin=0 -> result_o=0xFF, cout_o=0.
REQ-031 SHALL check: op=10, a=0xFF, cin=1 -> result_o=0x00, cout_o=1, ovf_o=0.
REQ-032 SHALL check: start_i pulsed with different operands during RUN -> ignored; result_o matches the first operation only.
REQ-033 SHALL check: rst_i at RUN cycle 4 -> next cycle ready_o=1, result_o=0, no done_o; a following add of 0x01+0x01 -> result_o=0x02.
REQ-034 SHALL check: start_i held high for 30 cycles -> done_o pulses at cycles 9, 19 and 29.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared types for the bit-serial adder controller: b-operand select encodings and FSM states.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      OP_ADD_B    = 2'b00,
      OP_ADD_NB   = 2'b01,
      OP_ADD_ZERO = 2'b10,
      OP_ADD_ONES = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StDone = 2'b10
   } state_e;

endpackage

// File: rtl/arithmetic_circuit.sv
// 1-bit arithmetic slice: full adder whose b input is selected/inverted/forced by sel_i.
module arithmetic_circuit
   import serial_arith_pkg::*;
(
   input  logic       a_i,
   input  logic       b_i,
   input  logic       cin_i,
   input  logic [1:0] sel_i,
   output logic       d_o,
   output logic       cout_o
);

   logic b_sel;

   always_comb begin
      b_sel = b_i;
      unique case (op_e'(sel_i))
         OP_ADD_B:    b_sel = b_i;
         OP_ADD_NB:   b_sel = ~b_i;
         OP_ADD_ZERO: b_sel = 1'b0;
         OP_ADD_ONES: b_sel = 1'b1;
         default:     b_sel = b_i;
      endcase
   end

   assign d_o    = a_i ^ b_sel ^ cin_i;
   assign cout_o = (a_i & b_sel) | (a_i & cin_i) | (b_sel & cin_i);

endmodule

// File: rtl/serial_arith_ctrl.sv
// Bit-serial adder controller, one bit per cycle LSB first through arithmetic_circuit.
// Optional ovf_o output enabled by defining SERIAL_ARITH_OVF_EN.
module serial_arith_ctrl
   import serial_arith_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic             ready_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
`ifdef SERIAL_ARITH_OVF_EN
   output logic             ovf_o,
`endif
   output logic             cout_o
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-2:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             cout_q, cout_d;
`ifdef SERIAL_ARITH_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic             slice_d, slice_cout;
   logic [WIDTH-1:0] shifted;

   arithmetic_circuit u_slice (
      .a_i    (a_q[cnt_q]),
      .b_i    (b_q[cnt_q]),
      .cin_i  (carry_q),
      .sel_i  (op_q),
      .d_o    (slice_d),
      .cout_o (slice_cout)
   );

   // New bit enters at the MSB; after WIDTH shifts bit 0 lands in position 0.
   assign shifted = {slice_d, shreg_q};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      shreg_d  = shreg_q;
      result_d = result_q;
      cout_d   = cout_q;
`ifdef SERIAL_ARITH_OVF_EN
      ovf_d    = ovf_q;
`endif
      ready_o  = 1'b0;
      busy_o   = 1'b0;
      done_o   = 1'b0;

      unique case (state_q)
         StIdle: begin
            ready_o = 1'b1;
            if (start_i) begin
               a_d     = a_i;
               b_d     = b_i;
               op_d    = op_i;
               carry_d = cin_i;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            busy_o  = 1'b1;
            shreg_d = shifted[WIDTH-1:1];
            carry_d = slice_cout;
            if (cnt_q == CntLast) begin
               result_d = shifted;
               cout_d   = slice_cout;
`ifdef SERIAL_ARITH_OVF_EN
               // carry_q here is the carry into the MSB
               ovf_d    = carry_q ^ slice_cout;
`endif
               state_d  = StDone;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            busy_o  = 1'b1;
            done_o  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         shreg_q  <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
`ifdef SERIAL_ARITH_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         shreg_q  <= shreg_d;
         result_q <= result_d;
         cout_q   <= cout_d;
`ifdef SERIAL_ARITH_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign result_o = result_q;
   assign cout_o   = cout_q;
`ifdef SERIAL_ARITH_OVF_EN
   assign ovf_o    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_arith_ctrl.sv
// Self-checking bench for serial_arith_ctrl (WIDTH=8): directed cases plus randomized ops vs a
// plain-arithmetic reference model. Checks ovf_o only when SERIAL_ARITH_OVF_EN is defined.
module tb_serial_arith_ctrl;

   localparam int W = 8;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic         start_i = 1'b0;
   logic [1:0]   op_i = '0;
   logic [W-1:0] a_i = '0;
   logic [W-1:0] b_i = '0;
   logic         cin_i = 1'b0;
   logic         ready_o, busy_o, done_o, cout_o;
   logic [W-1:0] result_o;
`ifdef SERIAL_ARITH_OVF_EN
   logic         ovf_o;
`endif

   int n_checks = 0;
   int n_errors = 0;

   serial_arith_ctrl #(.WIDTH(W)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .start_i  (start_i),
      .op_i     (op_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .cin_i    (cin_i),
      .ready_o  (ready_o),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .result_o (result_o),
`ifdef SERIAL_ARITH_OVF_EN
      .ovf_o    (ovf_o),
`endif
      .cout_o   (cout_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: whole-word arithmetic on the selected b operand.
   function automatic logic [W-1:0] model_opb(input logic [1:0] op, input logic [W-1:0] b);
      case (op)
         2'b00:   return b;
         2'b01:   return ~b;
         2'b10:   return '0;
         default: return '1;
      endcase
   endfunction

   function automatic logic [W:0] model_sum(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic cin);
      return {1'b0, a} + {1'b0, model_opb(op, b)} + {{W{1'b0}}, cin};
   endfunction

   function automatic logic model_ovf(input logic [1:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b, input logic cin);
      int sa, sb, s;
      logic [W-1:0] ob;
      ob = model_opb(op, b);
      sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
      sb = ob[W-1] ? int'(ob) - (1 << W) : int'(ob);
      s  = sa + sb + int'(cin);
      return (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
   endfunction

   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input bit disturb, output logic [W-1:0] res,
                         output logic co, output logic ov);
      int n;
      logic [W-1:0] prev;
      logic prev_c;
      bit held;
      logic [W:0] exp_sum;
      n = 0;
      while (!ready_o && n < 30) begin
         tick();
         n++;
      end
      check_eq("ready_wait", {31'd0, ready_o}, 32'd1);
      prev    = result_o;
      prev_c  = cout_o;
      held    = 1'b1;
      start_i = 1'b1;
      op_i    = op;
      a_i     = a;
      b_i     = b;
      cin_i   = cin;
      tick();
      start_i = 1'b0;
      n = 1;
      while (!done_o && n < W + 6) begin
         if (disturb) begin
            start_i = 1'b1;
            op_i    = 2'($urandom);
            a_i     = W'($urandom);
            b_i     = W'($urandom);
            cin_i   = 1'($urandom);
         end
         if (result_o !== prev || cout_o !== prev_c || busy_o !== 1'b1 || ready_o !== 1'b0)
            held = 1'b0;
         tick();
         n++;
      end
      start_i = 1'b0;
      check_eq("latency", n, W + 1);
      check_eq("hold_busy", {31'd0, held}, 32'd1);
      exp_sum = model_sum(op, a, b, cin);
      res = result_o;
      co  = cout_o;
`ifdef SERIAL_ARITH_OVF_EN
      ov  = ovf_o;
      check_eq("model_ovf", {31'd0, ov}, {31'd0, model_ovf(op, a, b, cin)});
`else
      ov  = model_ovf(op, a, b, cin);
`endif
      check_eq("model_result", {24'd0, res}, {24'd0, exp_sum[W-1:0]});
      check_eq("model_cout", {31'd0, co}, {31'd0, exp_sum[W]});
      tick();
      check_eq("idle_after_done", {29'd0, ready_o, busy_o, done_o}, 32'b100);
   endtask

   initial begin
      logic [W-1:0] r;
      logic c, v;
      bit saw_done;
      int done_cycles[$];

      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
      tick();
      check_eq("rst_flags", {29'd0, ready_o, busy_o, done_o}, 32'b100);
      check_eq("rst_result", {23'd0, cout_o, result_o}, 32'd0);

      run_op(2'b00, 8'h3C, 8'h45, 1'b0, 1'b0, r, c, v);
      check_eq("add_b_res", {24'd0, r}, 32'h81);
      check_eq("add_b_cout", {31'd0, c}, 32'd0);
`ifdef SERIAL_ARITH_OVF_EN
      check_eq("add_b_ovf", {31'd0, v}, 32'd1);
`endif

      run_op(2'b01, 8'h10, 8'h01, 1'b1, 1'b0, r, c, v);
      check_eq("add_nb_res", {24'd0, r}, 32'h0F);
      check_eq("add_nb_cout", {31'd0, c}, 32'd1);

      run_op(2'b11, 8'h00, 8'h5A, 1'b0, 1'b0, r, c, v);
      check_eq("add_ones_res", {24'd0, r}, 32'hFF);
      check_eq("add_ones_cout", {31'd0, c}, 32'd0);

      run_op(2'b10, 8'hFF, 8'h33, 1'b1, 1'b0, r, c, v);
      check_eq("add_zero_res", {24'd0, r}, 32'h00);
      check_eq("add_zero_cout", {31'd0, c}, 32'd1);
`ifdef SERIAL_ARITH_OVF_EN
      check_eq("add_zero_ovf", {31'd0, v}, 32'd0);
`endif

      // Start pulses with other operands during RUN must not disturb the first op.
      run_op(2'b00, 8'h12, 8'h34, 1'b1, 1'b1, r, c, v);
      check_eq("ignore_start_res", {24'd0, r}, 32'h47);

      // Reset asserted in RUN cycle 4.
      run_op(2'b00, 8'hAA, 8'h55, 1'b0, 1'b0, r, c, v);
      start_i = 1'b1;
      op_i    = 2'b00;
      a_i     = 8'hF0;
      b_i     = 8'h0F;
      cin_i   = 1'b1;
      tick();
      start_i = 1'b0;
      tick();
      tick();
      tick();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check_eq("midrun_rst_flags", {29'd0, ready_o, busy_o, done_o}, 32'b100);
      check_eq("midrun_rst_result", {23'd0, cout_o, result_o}, 32'd0);
      saw_done = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (done_o) saw_done = 1'b1;
         tick();
      end
      check_eq("midrun_rst_nodone", {31'd0, saw_done}, 32'd0);
      run_op(2'b00, 8'h01, 8'h01, 1'b0, 1'b0, r, c, v);
      check_eq("post_rst_add", {24'd0, r}, 32'h02);

      // start_i held high: one op per W+2 cycles.
      start_i = 1'b1;
      op_i    = 2'b00;
      a_i     = 8'h21;
      b_i     = 8'h43;
      cin_i   = 1'b0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (done_o) done_cycles.push_back(k + 1);
      end
      start_i = 1'b0;
      check_eq("held_count", done_cycles.size(), 3);
      for (int i = 0; i < done_cycles.size() && i < 3; i++)
         check_eq("held_done_cycle", done_cycles[i], 9 + 10 * i);
      check_eq("held_result", {24'd0, result_o}, 32'h64);

      for (int i = 0; i < 40; i++) begin
         run_op(2'($urandom), W'($urandom), W'($urandom), 1'($urandom),
                bit'($urandom_range(0, 3) == 0), r, c, v);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
